mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single 16 x 8 register file between the controller's instruction-fetch port (read-only) and the user program-load port (read/write). Replaces the static `op`-driven address mux with a req/ack arbiter. Each access is one serialised transaction. The block drives the register file's address, write-enable and write-data pins, and returns read data registered.

## Interface
- `ADDR_W`, 4: register-file address width.
- `DATA_W`, 8: register-file data width.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; forces the block to IDLE immediately.
- `cu_req` in 1: controller fetch request; held until `cu_ack`.
- `cu_address` in `ADDR_W`: controller read address; stable while `cu_req` is high.
- `cu_ack` out 1: one-cycle completion pulse for the controller.
- `usr_req` in 1: user request; held until `usr_ack`.
- `usr_wr` in 1: 1 = write, 0 = read; stable while `usr_req` is high.
- `usr_address` in `ADDR_W`: user address.
- `usr_wdata` in `DATA_W`: user write data.
- `usr_ack` out 1: one-cycle completion pulse for the user.
- `rd_data` out `DATA_W`: registered read result; valid in the ack cycle and held until the next read completes.
- `mem_address` out `ADDR_W`: to register file `address`.
- `mem_wr` out 1: to register file `wr`.
- `mem_in_data` out `DATA_W`: to register file `in_data`.
- `mem_out_data` in `DATA_W`: from register file `out_data`; combinational read.
- `busy` out 1: high in ACCESS and DONE.

## Operation
- FSM states: IDLE, ACCESS, DONE. Every transaction visits all three states.
- **IDLE**
  - No requests: stay in IDLE.
  - One request: grant it and go to ACCESS.
  - Both requests: arbitrate per the Configuration section.
  - On grant, latch into internal registers: the winner ID, its address, `wr` (forced 0 for the controller) and `wdata`.
- **ACCESS**
  - `mem_address` = latched address.
  - `mem_in_data` = latched wdata.
  - `mem_wr` = latched wr.
  - At the end of the cycle, `mem_out_data` is captured into `rd_data`, for reads only.
  - Next state is DONE.
- **DONE**
  - The winner's ack is high for exactly this cycle.
  - Next state is IDLE.
- Requests are sampled only in IDLE. A requester drops `req` on the edge that ends its ack cycle, so it cannot be re-serviced with stale data.
- Outside ACCESS:
  - `mem_wr` = 0.
  - `mem_address` and `mem_in_data` hold their last latched values; they are 0 after reset.
- A write leaves `rd_data` unchanged.
- Round-robin state:
  - `last_grant` holds the ID of the most recent winner.
  - On a tie, the requester that was not `last_grant` wins.
  - Reset value of `last_grant` is USR, so the controller wins the first tie.

## Timing
- Request first sampled high in IDLE at edge N:
  - ACCESS during cycle N+1.
  - ack and `rd_data` valid during cycle N+2.
  - Latency is 2 cycles from the sampling edge.
- Peak throughput is one transaction per 3 cycles.
- Under continuous contention, grants alternate CU, USR, CU, ...
- Reset values:
  - State = IDLE.
  - `cu_ack`, `usr_ack`, `busy`, `mem_wr` = 0.
  - `rd_data`, `mem_address`, `mem_in_data` = 0.
  - `last_grant` = USR.
- Reset asserted during ACCESS:
  - `mem_wr` drops asynchronously.
  - No write is committed at the following edge.
  - The transaction is lost with no ack; the requester reissues it.
- Reset asserted during DONE: the ack drops immediately.
- A request that arrives while `busy` is high waits in IDLE arbitration. It is never dropped.
- A request deasserted before being granted is ignored; no ack is issued for it.

## Configuration
- `ARB_CU_PRIORITY_EN`
  - Defined: fixed priority; `cu_req` always wins a tie, and `last_grant` is not consulted.
  - Undefined (default): round-robin as described under Operation.
- All other behaviour is identical in both builds.

## Test plan
- Reset, then a lone user write (`usr_wr`=1, addr 0x3, data 0xA5):
  - `mem_wr`=1 only in the cycle after the sampling edge.
  - `usr_ack` is pulsed 2 cycles after sampling.
  - A subsequent controller read of addr 0x3 returns `rd_data`=0xA5 with `cu_ack`.
- `cu_req` and `usr_req` both raised in the same cycle, each held and re-raised immediately after its ack:
  - Round-robin build: grant order CU, USR, CU, USR.
  - With `ARB_CU_PRIORITY_EN`: CU only, while CU keeps requesting.
- User read of addr 0xF after writing 0x5C:
  - `rd_data`=0x5C in the `usr_ack` cycle.
  - A following write to addr 0x0 leaves `rd_data`=0x5C.
- `reset` asserted mid-ACCESS of a user write of 0xFF to addr 0x7:
  - `mem_wr`=0 immediately; no ack.
  - Addr 0x7 keeps its previous contents.
  - All outputs return to their reset values.
- `cu_req` pulsed for one cycle while `busy` is high, then dropped:
  - No `cu_ack`.
  - The FSM returns to IDLE and stays there.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one register file between the controller's
// read-only fetch port and the user read/write program-load port.
// Each access is a serialised IDLE -> ACCESS -> DONE transaction.
// A tie between both requesters is settled round-robin by default.
// Define ARB_CU_PRIORITY_EN to make the controller always win a tie instead.
module mem_port_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cu_req,
    input  logic [ADDR_W-1:0] cu_address,
    output logic              cu_ack,
    input  logic              usr_req,
    input  logic              usr_wr,
    input  logic [ADDR_W-1:0] usr_address,
    input  logic [DATA_W-1:0] usr_wdata,
    output logic              usr_ack,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_in_data,
    input  logic [DATA_W-1:0] mem_out_data,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic ID_CU  = 1'b0;
    localparam logic ID_USR = 1'b1;

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_q, wr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    logic cu_wins_tie;
    logic grant_cu;
    logic grant_usr;

    // Arbitration: only an IDLE cycle can grant; the tie rule is build-selected.
    always_comb begin
`ifdef ARB_CU_PRIORITY_EN
        cu_wins_tie = 1'b1;
`else
        cu_wins_tie = (last_grant_q == ID_USR);
`endif
        grant_cu  = (state_q == S_IDLE) && cu_req && (!usr_req || cu_wins_tie);
        grant_usr = (state_q == S_IDLE) && usr_req && !grant_cu;
    end

    // State register: reset aborts any in-flight transaction without an ack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: every transaction walks IDLE -> ACCESS -> DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (grant_cu || grant_usr) state_d = S_ACCESS;
            S_ACCESS: state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Latch the winner's request on grant; capture read data at the end of ACCESS.
    always_comb begin
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wr_d         = wr_q;
        wdata_d      = wdata_q;
        rd_data_d    = rd_data_q;
        if (grant_cu) begin
            last_grant_d = ID_CU;
            addr_d       = cu_address;
            wr_d         = 1'b0;
            wdata_d      = '0;
        end else if (grant_usr) begin
            last_grant_d = ID_USR;
            addr_d       = usr_address;
            wr_d         = usr_wr;
            wdata_d      = usr_wdata;
        end
        if ((state_q == S_ACCESS) && !wr_q) begin
            rd_data_d = mem_out_data;
        end
    end

    // Transaction registers: address/data hold their last values between accesses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= ID_USR;
            addr_q       <= '0;
            wr_q         <= 1'b0;
            wdata_q      <= '0;
            rd_data_q    <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wr_q         <= wr_d;
            wdata_q      <= wdata_d;
            rd_data_q    <= rd_data_d;
        end
    end

    // Outputs decoded from state so reset drops write-enable and acks at once.
    always_comb begin
        mem_wr  = (state_q == S_ACCESS) && wr_q;
        cu_ack  = (state_q == S_DONE) && (last_grant_q == ID_CU);
        usr_ack = (state_q == S_DONE) && (last_grant_q == ID_USR);
        busy    = (state_q != S_IDLE);
    end

    assign mem_address = addr_q;
    assign mem_in_data = wdata_q;
    assign rd_data     = rd_data_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of mem_port_arbiter
// against a register-file model and a transaction-level reference.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam bit CU  = 1'b0;
    localparam bit USR = 1'b1;

    logic              clk = 1'b0;
    logic              reset;
    logic              cu_req;
    logic [ADDR_W-1:0] cu_address;
    logic              cu_ack;
    logic              usr_req;
    logic              usr_wr;
    logic [ADDR_W-1:0] usr_address;
    logic [DATA_W-1:0] usr_wdata;
    logic              usr_ack;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_in_data;
    logic [DATA_W-1:0] mem_out_data;
    logic              busy;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
        .cu_req(cu_req), .cu_address(cu_address), .cu_ack(cu_ack),
        .usr_req(usr_req), .usr_wr(usr_wr), .usr_address(usr_address),
        .usr_wdata(usr_wdata), .usr_ack(usr_ack), .rd_data(rd_data),
        .mem_address(mem_address), .mem_wr(mem_wr), .mem_in_data(mem_in_data),
        .mem_out_data(mem_out_data), .busy(busy)
    );

    // Register file: synchronous write, combinational read.
    logic [DATA_W-1:0] rf [16] = '{default: 8'h00};
    always @(posedge clk) if (mem_wr) rf[mem_address] <= mem_in_data;
    assign mem_out_data = rf[mem_address];

    // Reference state
    int                checks = 0;
    int                errors = 0;
    logic [DATA_W-1:0] ref_mem [16] = '{default: 8'h00};
    logic [DATA_W-1:0] model_rd = 8'h00;
    bit                model_last = USR;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cu_ack"}, cu_ack, 0);
        chk({tag, "_usr_ack"}, usr_ack, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_mem_wr"}, mem_wr, 0);
        chk({tag, "_rd_data"}, rd_data, 0);
        chk({tag, "_mem_address"}, mem_address, 0);
        chk({tag, "_mem_in_data"}, mem_in_data, 0);
    endtask

    // Lone user transaction from IDLE with exact cycle timing.
    task automatic usr_xact(input bit wr, input logic [3:0] a, input logic [7:0] d);
        usr_req = 1'b1; usr_wr = wr; usr_address = a; usr_wdata = d;
        tick;
        chk("usr_acc_busy", busy, 1);
        chk("usr_acc_mem_wr", mem_wr, wr);
        chk("usr_acc_addr", mem_address, a);
        chk("usr_acc_ack", usr_ack, 0);
        if (wr) chk("usr_acc_wdata", mem_in_data, d);
        tick;
        chk("usr_done_ack", usr_ack, 1);
        chk("usr_done_cu_ack", cu_ack, 0);
        chk("usr_done_mem_wr", mem_wr, 0);
        if (wr) ref_mem[a] = d;
        else    model_rd = ref_mem[a];
        chk("usr_done_rd_data", rd_data, model_rd);
        usr_req = 1'b0; model_last = USR;
        tick;
        chk("usr_post_ack", usr_ack, 0);
        chk("usr_post_busy", busy, 0);
    endtask

    // Lone controller read from IDLE with exact cycle timing.
    task automatic cu_xact(input logic [3:0] a);
        cu_req = 1'b1; cu_address = a;
        tick;
        chk("cu_acc_busy", busy, 1);
        chk("cu_acc_mem_wr", mem_wr, 0);
        chk("cu_acc_addr", mem_address, a);
        tick;
        chk("cu_done_ack", cu_ack, 1);
        chk("cu_done_usr_ack", usr_ack, 0);
        model_rd = ref_mem[a];
        chk("cu_done_rd_data", rd_data, model_rd);
        cu_req = 1'b0; model_last = CU;
        tick;
        chk("cu_post_ack", cu_ack, 0);
    endtask

    initial begin
        int acks;
        int cnt;
        bit got;
        bit exp_order [4];
        bit exp_q [$];
        bit c, u, u_wr;
        logic [3:0] c_a, u_a;
        logic [7:0] u_d;

        reset = 1'b1; cu_req = 1'b0; cu_address = '0;
        usr_req = 1'b0; usr_wr = 1'b0; usr_address = '0; usr_wdata = '0;
        repeat (2) tick;
        reset = 1'b0;
        tick;
        chk_reset_outputs("rst");

        // Lone write, then controller reads it back
        usr_xact(1'b1, 4'h3, 8'hA5);
        cu_xact(4'h3);
        chk("cu_read_a5", rd_data, 8'hA5);

        // User write/read of 0xF, then a write that must not disturb rd_data
        usr_xact(1'b1, 4'hF, 8'h5C);
        usr_xact(1'b0, 4'hF, 8'h00);
        chk("usr_read_5c", rd_data, 8'h5C);
        usr_xact(1'b1, 4'h0, 8'h3E);
        chk("wr_keeps_rd", rd_data, 8'h5C);

        // Reset during ACCESS of a write
        usr_xact(1'b1, 4'h7, 8'h11);
        usr_req = 1'b1; usr_wr = 1'b1; usr_address = 4'h7; usr_wdata = 8'hFF;
        tick;
        chk("rstacc_pre_mem_wr", mem_wr, 1);
        reset = 1'b1;
        #1;
        chk("rstacc_async_mem_wr", mem_wr, 0);
        chk("rstacc_async_busy", busy, 0);
        usr_req = 1'b0;
        tick;
        reset = 1'b0;
        cnt = 0;
        repeat (4) begin tick; if (usr_ack) cnt++; end
        chk("rstacc_no_ack", cnt, 0);
        chk("rstacc_mem7", rf[7], 8'h11);
        chk_reset_outputs("rstacc");
        model_rd = 8'h00; model_last = USR;

        // Reset during DONE drops the ack at once
        cu_req = 1'b1; cu_address = 4'h3;
        repeat (2) tick;
        chk("rstdone_pre_ack", cu_ack, 1);
        reset = 1'b1;
        #1;
        chk("rstdone_async_ack", cu_ack, 0);
        cu_req = 1'b0;
        tick;
        reset = 1'b0;
        tick;
        chk_reset_outputs("rstdone");
        model_rd = 8'h00; model_last = USR;

        // Continuous contention right after reset
`ifdef ARB_CU_PRIORITY_EN
        exp_order = '{CU, CU, CU, CU};
`else
        exp_order = '{CU, USR, CU, USR};
`endif
        cu_req = 1'b1; cu_address = 4'h3;
        usr_req = 1'b1; usr_wr = 1'b0; usr_address = 4'hF;
        acks = 0;
        for (int cyc = 0; cyc < 60 && acks < 4; cyc++) begin
            tick;
            if (cu_ack || usr_ack) begin
                chk("cont_single_ack", cu_ack && usr_ack, 0);
                got = usr_ack ? USR : CU;
                chk("cont_order", got, exp_order[acks]);
                model_rd = ref_mem[got == CU ? 4'h3 : 4'hF];
                chk("cont_rd_data", rd_data, model_rd);
                model_last = got;
                acks++;
            end
        end
        chk("cont_ack_count", acks, 4);
        cu_req = 1'b0; usr_req = 1'b0;
        cnt = 0;
        repeat (4) begin tick; if (cu_ack || usr_ack) cnt++; end
        chk("cont_dropped_ignored", cnt, 0);
        chk("cont_idle", busy, 0);

        // One-cycle cu_req pulse while busy is ignored
        usr_req = 1'b1; usr_wr = 1'b0; usr_address = 4'h3;
        tick;
        cu_req = 1'b1; cu_address = 4'h2;
        tick;
        chk("pulse_usr_ack", usr_ack, 1);
        model_rd = ref_mem[3]; model_last = USR;
        chk("pulse_rd_data", rd_data, model_rd);
        cu_req = 1'b0; usr_req = 1'b0;
        cnt = 0;
        repeat (6) begin tick; if (cu_ack || busy) cnt++; end
        chk("pulse_no_cu_ack", cnt, 0);

        // Randomized rounds against the transaction-level model
        for (int r = 0; r < 40; r++) begin
            c = 1'($urandom); u = 1'($urandom);
            if (!c && !u) c = 1'b1;
            c_a = 4'($urandom); u_a = 4'($urandom); u_d = 8'($urandom); u_wr = 1'($urandom);
            exp_q.delete();
            if (c && u) begin
`ifdef ARB_CU_PRIORITY_EN
                got = CU;
`else
                got = (model_last == USR) ? CU : USR;
`endif
                exp_q.push_back(got);
                exp_q.push_back(!got);
            end else begin
                exp_q.push_back(c ? CU : USR);
            end
            cu_req = c; cu_address = c_a;
            usr_req = u; usr_wr = u_wr; usr_address = u_a; usr_wdata = u_d;
            for (int cyc = 0; cyc < 30 && exp_q.size() > 0; cyc++) begin
                tick;
                if (cu_ack || usr_ack) begin
                    chk("rnd_single_ack", cu_ack && usr_ack, 0);
                    got = usr_ack ? USR : CU;
                    chk("rnd_order", got, exp_q[0]);
                    void'(exp_q.pop_front());
                    if (got == CU) begin
                        model_rd = ref_mem[c_a];
                        cu_req = 1'b0;
                    end else begin
                        if (u_wr) ref_mem[u_a] = u_d;
                        else      model_rd = ref_mem[u_a];
                        usr_req = 1'b0;
                    end
                    chk("rnd_rd_data", rd_data, model_rd);
                    model_last = got;
                end
            end
            chk("rnd_timeout", exp_q.size(), 0);
            cu_req = 1'b0; usr_req = 1'b0;
            repeat ($urandom_range(0, 2)) tick;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
